// File: rtl/scroller_pkg.sv
// Shared constants, state type and helpers for the parallax scroll sequencer.
package scroller_pkg;

    localparam int NUM_LAYERS = 4;
    localparam int LFSR_W     = 9;
    localparam int PHASE_W    = 3;
    localparam int PRESC_W    = 3;

    // Skyline LFSR feedback taps: new bit0 = bit[TAP_HI] ^ bit[TAP_LO]
    localparam int LFSR_TAP_HI = 8;
    localparam int LFSR_TAP_LO = 4;

    // Values every layer returns to on reset
    localparam logic [LFSR_W-1:0]  LFSR_SEED  = 9'h1FF;
    localparam logic [PHASE_W-1:0] PHASE_SEED = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_ADVANCE = 1'b1
    } state_t;

    // Prescaler bits that must be zero for layer k to advance this frame.
    // Layers beyond the prescaler width only advance when the whole prescaler is zero.
    function automatic logic [PRESC_W-1:0] sel_mask(input int unsigned k);
        logic [PRESC_W-1:0] m;
        if (k >= 32'(PRESC_W)) begin
            m = {PRESC_W{1'b1}};
        end else begin
            m = PRESC_W'((32'd1 << k) - 32'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_stepper.sv
// Single combinational step of a skyline LFSR: shift left, feedback into bit0.
module lfsr_stepper #(
    parameter int W = scroller_pkg::LFSR_W
) (
    input  logic [W-1:0] lfsr_in,
    output logic [W-1:0] lfsr_out
);
    import scroller_pkg::*;

    assign lfsr_out = {lfsr_in[W-2:0], lfsr_in[LFSR_TAP_HI] ^ lfsr_in[LFSR_TAP_LO]};

endmodule

// File: rtl/scroll_layer_sequencer.sv
// Per-frame parallax layer sequencer: walks the layers one per cycle after each
// accepted frame tick, advancing phase/LFSR state of the layers the prescaler
// selects, and issues line-load strobes that never expose half-advanced state.
module scroll_layer_sequencer #(
    parameter int NUM_LAYERS = scroller_pkg::NUM_LAYERS,
    parameter int LFSR_W     = scroller_pkg::LFSR_W,
    parameter int PHASE_W    = scroller_pkg::PHASE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_tick,
    input  logic                         line_start,
    input  logic                         pause,
    output logic [NUM_LAYERS*LFSR_W-1:0]  layer_lfsr,
    output logic [NUM_LAYERS*PHASE_W-1:0] layer_phase,
    output logic                         load_strobe,
    output logic                         busy,
    output logic                         adv_done,
    output logic                         overrun
);
    import scroller_pkg::*;

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [PRESC_W-1:0]             presc_q, presc_d;
    logic [PRESC_W-1:0]             p_q, p_d;
    logic                           pending_q, pending_d;
    logic [NUM_LAYERS*LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [NUM_LAYERS*PHASE_W-1:0]  phase_q, phase_d;
    logic                           load_strobe_q, load_strobe_d;
    logic                           busy_q, busy_d;
    logic                           adv_done_q, adv_done_d;
    logic                           overrun_q, overrun_d;

    logic                           frame_ok_s;
    logic                           layer_sel_s;
    logic [LFSR_W-1:0]              cur_lfsr_s;
    logic [LFSR_W-1:0]              next_lfsr_s;
    logic [PHASE_W-1:0]             cur_phase_s;

    // Layer currently addressed by idx feeds the one shared stepper
    assign cur_lfsr_s  = lfsr_q[idx_q*LFSR_W +: LFSR_W];
    assign cur_phase_s = phase_q[idx_q*PHASE_W +: PHASE_W];
    assign frame_ok_s  = frame_tick & ~pause;
    assign layer_sel_s = ((p_q & sel_mask(32'(idx_q))) == PRESC_W'(0));

    lfsr_stepper #(
        .W (LFSR_W)
    ) u_lfsr_stepper (
        .lfsr_in  (cur_lfsr_s),
        .lfsr_out (next_lfsr_s)
    );

    // Next-state, per-layer update and output pulse generation
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        presc_d       = presc_q;
        p_d           = p_q;
        pending_d     = pending_q;
        lfsr_d        = lfsr_q;
        phase_d       = phase_q;
        load_strobe_d = 1'b0;
        adv_done_d    = 1'b0;
        overrun_d     = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (frame_ok_s) begin
                    // Snapshot the prescaler so every layer this frame sees the same P
                    state_d   = ST_ADVANCE;
                    idx_d     = {IDX_W{1'b0}};
                    p_d       = presc_q;
                    presc_d   = presc_q + PRESC_W'(1);
                    // A line arriving with the tick must wait for the advanced state
                    pending_d = line_start;
                end else begin
                    load_strobe_d = line_start;
                end
            end
            ST_ADVANCE: begin
                if (frame_ok_s) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end

                if (line_start) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end

                if (layer_sel_s) begin
                    phase_d[idx_q*PHASE_W +: PHASE_W] = cur_phase_s + PHASE_W'(1);
                    if (cur_phase_s == {PHASE_W{1'b1}}) begin
                        lfsr_d[idx_q*LFSR_W +: LFSR_W] = next_lfsr_s;
                    end else begin
                        lfsr_d[idx_q*LFSR_W +: LFSR_W] = cur_lfsr_s;
                    end
                end else begin
                    phase_d[idx_q*PHASE_W +: PHASE_W] = cur_phase_s;
                end

                if (idx_q == LAST_IDX) begin
                    state_d       = ST_IDLE;
                    idx_d         = {IDX_W{1'b0}};
                    adv_done_d    = 1'b1;
                    // Deferred line loads collapse into one strobe alongside adv_done
                    load_strobe_d = pending_q | line_start;
                    pending_d     = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                idx_d     = {IDX_W{1'b0}};
                pending_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_ADVANCE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= {IDX_W{1'b0}};
            presc_q       <= {PRESC_W{1'b0}};
            p_q           <= {PRESC_W{1'b0}};
            pending_q     <= 1'b0;
            lfsr_q        <= {NUM_LAYERS{LFSR_W'(LFSR_SEED)}};
            phase_q       <= {NUM_LAYERS{PHASE_W'(PHASE_SEED)}};
            load_strobe_q <= 1'b0;
            busy_q        <= 1'b0;
            adv_done_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            presc_q       <= presc_d;
            p_q           <= p_d;
            pending_q     <= pending_d;
            lfsr_q        <= lfsr_d;
            phase_q       <= phase_d;
            load_strobe_q <= load_strobe_d;
            busy_q        <= busy_d;
            adv_done_q    <= adv_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign layer_lfsr  = lfsr_q;
    assign layer_phase = phase_q;
    assign load_strobe = load_strobe_q;
    assign busy        = busy_q;
    assign adv_done    = adv_done_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/scroll_layer_sequencer.md
SCROLL_LAYER_SEQUENCER -- requirements
Module: scroll_layer_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 4, meaning the number of parallax layers sequenced.
REQ-002 The block SHALL have parameter LFSR_W, default 9, meaning the width of each layer's skyline LFSR.
REQ-003 The block SHALL have parameter PHASE_W, default 3, meaning the width of each layer's sub-column phase counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset: synchronous, active-low.
REQ-006 The block SHALL have port frame_tick, input, 1 bit, a one-cycle pulse once per frame.
REQ-007 The block SHALL have port line_start, input, 1 bit, a one-cycle pulse once per scanline.
REQ-008 The block SHALL have port pause, input, 1 bit: while high, frame_tick is ignored.
REQ-009 The block SHALL have port layer_lfsr, output, NUM_LAYERS*LFSR_W bits, the per-layer base LFSR state, with layer k in bits [k*LFSR_W +: LFSR_W].
REQ-010 The block SHALL have port layer_phase, output, NUM_LAYERS*PHASE_W bits, the per-layer base phase, packed the same way as layer_lfsr.
REQ-011 The block SHALL have port load_strobe, output, 1 bit, a one-cycle pulse telling the datapath to copy the base state into its working counters.
REQ-012 The block SHALL have port busy, output, 1 bit, high while an advance sequence is in progress.
REQ-013 The block SHALL have port adv_done, output, 1 bit, a one-cycle pulse when an advance sequence completes.
REQ-014 The block SHALL have port overrun, output, 1 bit, a sticky flag for a frame_tick lost while busy.

Function
REQ-015 The block SHALL implement an FSM with states IDLE and ADVANCE, plus a layer index idx of width clog2(NUM_LAYERS).
REQ-016 In IDLE, when frame_tick=1 and pause=0, the block SHALL latch prescaler value P, enter ADVANCE with idx=0, and then increment the 3-bit prescaler modulo 8.
REQ-017 In ADVANCE, the block SHALL process exactly one layer per cycle (idx=0..NUM_LAYERS-1), so layer k's registers update at the (k+1)-th edge after the edge that sampled frame_tick.
REQ-018 Layer k SHALL be selected for advance if and only if P mod 2^k == 0: layer 0 every frame, layer 1 every 2nd frame, layer 3 every 8th frame.
REQ-019 A selected layer SHALL increment its phase modulo 2^PHASE_W.
REQ-020 When a selected layer's phase wraps from 2^PHASE_W-1 to 0, that layer's LFSR SHALL step once: shift left, bit0 = bit8 XOR bit4.
REQ-021 Unselected layers SHALL hold their phase and LFSR unchanged.
REQ-022 One shared LFSR stepper SHALL serve all layers, time-multiplexed by idx.
REQ-023 After processing the last layer, the FSM SHALL return to IDLE, with adv_done high for the one cycle following the final update.
REQ-024 busy SHALL be high exactly during the NUM_LAYERS cycles the FSM spends in ADVANCE.
REQ-025 A line_start sampled in IDLE SHALL produce load_strobe high on the following cycle.
REQ-026 A line_start sampled while busy, or in the same cycle as an accepted frame_tick, SHALL set a pending flag; load_strobe SHALL then fire in the same cycle as adv_done, so the line sees the advanced state.
REQ-027 Multiple line_starts while pending SHALL collapse into a single load_strobe.
REQ-028 A frame_tick sampled while busy SHALL be dropped, SHALL not change the prescaler, and SHALL set overrun; overrun clears only on reset.
REQ-029 A frame_tick with pause=1 SHALL be ignored entirely; line loads SHALL continue normally during pause.
REQ-030 layer_lfsr and layer_phase SHALL change only during ADVANCE; all outputs SHALL be registered.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set: state=IDLE, idx=0, prescaler=0, pending=0, every LFSR=all ones (9'h1FF), every phase=all ones (3'd7), and load_strobe, busy, adv_done and overrun all 0.
REQ-032 A reset asserted mid-ADVANCE SHALL abort the sequence with no partial-layer effects surviving; the reset values above apply.

Structure
REQ-033 A shared package scroller_pkg SHALL hold NUM_LAYERS, LFSR_W, PHASE_W, the LFSR tap positions, the LFSR/phase reset seeds, and the FSM state type.
REQ-034 The block SHALL use one combinational sub-module, lfsr_stepper (LFSR_W in, LFSR_W out), instantiated once.

Verification
REQ-035 Reset, then frame_tick with pause=0 -> busy high for 4 cycles; all four phases read 0 and all LFSRs read 9'h1FE; adv_done pulses once.
REQ-036 Second frame_tick (P=1) -> layer0 phase 0->1 and layers 1-3 unchanged; the 8th tick after reset (P=7) leaves layer3 untouched, and the 9th tick (P=0) advances layer3.
REQ-037 line_start in IDLE -> load_strobe exactly 1 cycle later; line_start in the same cycle as frame_tick -> load_strobe coincident with adv_done, with the values already advanced.
REQ-038 Second frame_tick 2 cycles after the first -> dropped, overrun=1, and prescaler advanced only once.
REQ-039 pause=1 with 3 frame_ticks -> no state change and no busy, while line_start still yields load_strobe.
REQ-040 rst_n low during idx=2 -> next cycle shows IDLE with all LFSRs at 9'h1FF, all phases at 7, and busy=0.
